// File: rtl/dds_multi_core_if.sv
// Configuration write/commit channel for the multi-channel DDS engine.
// The master side drives field writes and commit pulses; the DDS core is the slave.
interface dds_multi_core_if #(
  parameter int ACC_W = 16
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_chan;
  logic [1:0]       cfg_addr;
  logic [ACC_W-1:0] cfg_data;
  logic             cfg_commit;

  modport master (
    output cfg_valid, cfg_chan, cfg_addr, cfg_data, cfg_commit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_addr, cfg_data, cfg_commit,
    output cfg_ready
  );
endinterface

// File: rtl/dds_multi_core.sv
// Multi-channel DDS: per-channel phase accumulators with shadowed config applied atomically
// on commit, feeding a 2-stage phase/waveform pipeline (sine, square, saw, triangle).
module dds_multi_core #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 16,
  parameter int PHASE_W  = 10,
  parameter int OUT_W    = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  dds_multi_core_if.slave           cfg,
  output logic                      out_valid,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic [CHANNELS-1:0]       sync
);

  localparam int QN = 1 << (PHASE_W - 2);
  localparam int PN = 1 << PHASE_W;
  localparam int H  = 1 << (OUT_W - 1);
  localparam logic [OUT_W-1:0] HALF    = OUT_W'(H);
  localparam logic [OUT_W-2:0] AMP_MAX = '1;

  typedef enum logic [1:0] {MODE_SINE, MODE_SQUARE, MODE_SAW, MODE_TRI} mode_e;
  typedef enum logic [1:0] {FIELD_TUNE, FIELD_OFFSET, FIELD_MODE, FIELD_CLEAR} field_e;

  // Elaboration-time quarter sine; the Taylor series is exact well below rounding resolution.
  function automatic logic [OUT_W-2:0] quarter_sine(input int idx);
    real x;
    real term;
    real s;
    x    = 6.283185307179586 * real'(idx) / real'(PN);
    term = x;
    s    = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    return (OUT_W-1)'($rtoi(real'(H - 1) * s + 0.5));
  endfunction

  logic [OUT_W-2:0] sine_lut [QN];

  for (genvar i = 0; i < QN; i++) begin : g_lut
    localparam logic [OUT_W-2:0] V = quarter_sine(i);
    assign sine_lut[i] = V;
  end

  logic v1;

  assign cfg.cfg_ready = ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= en;
      out_valid <= v1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ACC_W-1:0]   sh_tune, tune, acc;
    logic [PHASE_W-1:0] sh_off, off, p1;
    mode_e              sh_mode, mode, mode1;
    logic               sh_clr, wr, sync_r;
    logic [ACC_W:0]     sum;
    logic [PHASE_W-3:0] qidx;
    logic [PHASE_W-2:0] tri_q;
    logic [OUT_W-2:0]   amp;
    logic [OUT_W-1:0]   sine_val, saw_val, tri_val, out_r;

    assign wr  = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_chan == 2'(c));
    assign sum = {1'b0, acc} + {1'b0, tune};

    // A write in the commit cycle lands only in the shadow, so it also wins over the clear-flag reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sh_tune <= '0;
        sh_off  <= '0;
        sh_mode <= MODE_SINE;
        sh_clr  <= 1'b0;
      end else begin
        if (cfg.cfg_commit) sh_clr <= 1'b0;
        if (wr) begin
          case (field_e'(cfg.cfg_addr))
            FIELD_TUNE:   sh_tune <= cfg.cfg_data;
            FIELD_OFFSET: sh_off  <= cfg.cfg_data[PHASE_W-1:0];
            FIELD_MODE:   sh_mode <= mode_e'(cfg.cfg_data[1:0]);
            FIELD_CLEAR:  sh_clr  <= 1'b1;
          endcase
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tune   <= '0;
        off    <= '0;
        mode   <= MODE_SINE;
        acc    <= '0;
        sync_r <= 1'b0;
      end else begin
        if (cfg.cfg_commit) begin
          tune <= sh_tune;
          off  <= sh_off;
          mode <= sh_mode;
        end
        if (cfg.cfg_commit && sh_clr) begin
          acc    <= '0;
          sync_r <= 1'b0;
        end else if (en) begin
          acc    <= sum[ACC_W-1:0];
          sync_r <= sum[ACC_W];
        end else begin
          sync_r <= 1'b0;
        end
      end
    end

    // Quadrants 1 and 3 read the table mirrored; their first point (peak) is not stored.
    assign qidx     = (PHASE_W-2)'(0) - (p1[PHASE_W-2] ? p1[PHASE_W-3:0] : (PHASE_W-2)'(0))
                      + (p1[PHASE_W-2] ? (PHASE_W-2)'(0) : p1[PHASE_W-3:0]);
    assign amp      = (p1[PHASE_W-2] && (p1[PHASE_W-3:0] == '0)) ? AMP_MAX : sine_lut[qidx];
    assign sine_val = p1[PHASE_W-1] ? (HALF - {1'b0, amp}) : (HALF + {1'b0, amp});
    assign tri_q    = p1[PHASE_W-1] ? ~p1[PHASE_W-2:0] : p1[PHASE_W-2:0];

    if (PHASE_W >= OUT_W) begin : g_saw_trunc
      assign saw_val = p1[PHASE_W-1 -: OUT_W];
    end else begin : g_saw_fill
      assign saw_val = {p1, {(OUT_W-PHASE_W){1'b0}}};
    end

    if (PHASE_W - 1 >= OUT_W) begin : g_tri_trunc
      assign tri_val = tri_q[PHASE_W-2 -: OUT_W];
    end else begin : g_tri_fill
      assign tri_val = {tri_q, {(OUT_W-PHASE_W+1){1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p1    <= '0;
        mode1 <= MODE_SINE;
        out_r <= '0;
      end else begin
        p1    <= acc[ACC_W-1 -: PHASE_W] + off;
        mode1 <= mode;
        case (mode1)
          MODE_SINE:   out_r <= sine_val;
          MODE_SQUARE: out_r <= p1[PHASE_W-1] ? '0 : '1;
          MODE_SAW:    out_r <= saw_val;
          MODE_TRI:    out_r <= tri_val;
        endcase
      end
    end

    assign out_data[c*OUT_W +: OUT_W] = out_r;
    assign sync[c]                    = sync_r;
  end

endmodule

// File: tb/tb_dds_multi_core.sv
// Self-checking bench for dds_multi_core: table-driven waveform points, directed multi-cycle
// sequences and randomized traffic, all compared against a cycle-level behavioural model.
module tb_dds_multi_core;
  localparam int CH      = 2;
  localparam int ACC_W   = 16;
  localparam int PHASE_W = 10;
  localparam int OUT_W   = 12;
  localparam int PN      = 1 << PHASE_W;
  localparam int AN      = 1 << ACC_W;
  localparam int H       = 1 << (OUT_W - 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic                   out_valid;
  logic [CH*OUT_W-1:0]    out_data;
  logic [CH-1:0]          sync;

  dds_multi_core_if #(.ACC_W(ACC_W)) cfg_bus ();

  dds_multi_core #(
    .CHANNELS(CH), .ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg      (cfg_bus),
    .out_valid(out_valid),
    .out_data (out_data),
    .sync     (sync)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: shadow fields for all four addressable channels, active state per real channel.
  int m_sh_tune [4];
  int m_sh_off  [4];
  int m_sh_mode [4];
  bit m_sh_clr  [4];
  int m_tune [CH];
  int m_off  [CH];
  int m_mode [CH];
  int m_acc  [CH];
  int m_pp   [CH];
  int m_pm   [CH];
  int m_out  [CH];
  bit m_sync [CH];
  bit m_v1;
  bit m_valid;

  typedef struct {
    string name;
    int    offset;
    int    mode;
    int    expected;
  } vec_t;

  vec_t vecs [14];

  function automatic int waveRef(input int p, input int mode);
    real v;
    int  r;
    case (mode)
      0: begin
        v = real'(H - 1) * $sin(2.0 * 3.14159265358979323846 * real'(p) / real'(PN));
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        waveRef = H + r;
      end
      1:       waveRef = (p < PN / 2) ? (2 * H - 1) : 0;
      2:       waveRef = p * (1 << (OUT_W - PHASE_W));
      default: waveRef = ((p >= PN / 2) ? (PN - 1 - p) : p) * (1 << (OUT_W - PHASE_W + 1));
    endcase
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) begin
      m_sh_tune[i] = 0; m_sh_off[i] = 0; m_sh_mode[i] = 0; m_sh_clr[i] = 1'b0;
    end
    for (int c = 0; c < CH; c++) begin
      m_tune[c] = 0; m_off[c] = 0; m_mode[c] = 0; m_acc[c] = 0;
      m_pp[c] = 0; m_pm[c] = 0; m_out[c] = 0; m_sync[c] = 1'b0;
    end
    m_v1    = 1'b0;
    m_valid = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs that were stable before that edge.
  function automatic void modelEdge();
    int s;
    int ch;
    if (rst) begin
      modelReset();
      return;
    end
    for (int c = 0; c < CH; c++) begin
      m_out[c] = waveRef(m_pp[c], m_pm[c]);
      m_pp[c]  = ((m_acc[c] / (1 << (ACC_W - PHASE_W))) + m_off[c]) % PN;
      m_pm[c]  = m_mode[c];
    end
    m_valid = m_v1;
    m_v1    = en;
    for (int c = 0; c < CH; c++) begin
      s = m_acc[c] + m_tune[c];
      if (cfg_bus.cfg_commit && m_sh_clr[c]) begin
        m_acc[c] = 0; m_sync[c] = 1'b0;
      end else if (en) begin
        m_acc[c] = s % AN; m_sync[c] = (s >= AN);
      end else begin
        m_sync[c] = 1'b0;
      end
    end
    if (cfg_bus.cfg_commit) begin
      for (int c = 0; c < CH; c++) begin
        m_tune[c] = m_sh_tune[c]; m_off[c] = m_sh_off[c]; m_mode[c] = m_sh_mode[c];
      end
      for (int i = 0; i < 4; i++) m_sh_clr[i] = 1'b0;
    end
    if (cfg_bus.cfg_valid) begin
      ch = int'(cfg_bus.cfg_chan);
      if (ch < CH) begin
        case (int'(cfg_bus.cfg_addr))
          0:       m_sh_tune[ch] = int'(cfg_bus.cfg_data);
          1:       m_sh_off[ch]  = int'(cfg_bus.cfg_data) % PN;
          2:       m_sh_mode[ch] = int'(cfg_bus.cfg_data) % 4;
          default: m_sh_clr[ch]  = 1'b1;
        endcase
      end
    end
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic checkOutput();
    logic [CH*OUT_W-1:0] e;
    logic [CH-1:0]       s;
    for (int c = 0; c < CH; c++) begin
      e[c*OUT_W +: OUT_W] = OUT_W'(m_out[c]);
      s[c]                = m_sync[c];
    end
    check("out_data", 64'(out_data), 64'(e));
    check("sync", 64'(sync), 64'(s));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("cfg_ready", 64'(cfg_bus.cfg_ready), 64'(!rst));
  endtask

  task automatic applyStimulus(input logic r, input logic v, input int chan, input int addr,
                               input int data, input logic commit, input logic e);
    rst                = r;
    en                 = e;
    cfg_bus.cfg_valid  = v;
    cfg_bus.cfg_chan   = 2'(chan);
    cfg_bus.cfg_addr   = 2'(addr);
    cfg_bus.cfg_data   = ACC_W'(data);
    cfg_bus.cfg_commit = commit;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic cfgWrite(input int chan, input int addr, input int data, input logic e);
    applyStimulus(1'b0, 1'b1, chan, addr, data, 1'b0, e);
  endtask

  task automatic commitStep(input logic e);
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, e);
  endtask

  task automatic idle(input int n, input logic e);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, e);
  endtask

  function automatic int chOut(input int c);
    return int'(out_data[c*OUT_W +: OUT_W]);
  endfunction

  initial begin
    int prev;
    int prev1;
    int sync_cnt;

    vecs[0]  = '{"sine_p0",      0, 0, 2048};
    vecs[1]  = '{"sine_p256",  256, 0, 4095};
    vecs[2]  = '{"sine_p512",  512, 0, 2048};
    vecs[3]  = '{"sine_p768",  768, 0, 1};
    vecs[4]  = '{"sine_p1",      1, 0, 2061};
    vecs[5]  = '{"sine_p128",  128, 0, 3495};
    vecs[6]  = '{"square_p0",    0, 1, 4095};
    vecs[7]  = '{"square_p511",511, 1, 4095};
    vecs[8]  = '{"square_p512",512, 1, 0};
    vecs[9]  = '{"saw_p1",       1, 2, 4};
    vecs[10] = '{"saw_p1023", 1023, 2, 4092};
    vecs[11] = '{"tri_p511",   511, 3, 4088};
    vecs[12] = '{"tri_p512",   512, 3, 4088};
    vecs[13] = '{"tri_p1023", 1023, 3, 0};

    modelReset();
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("default_h", 64'(out_data), 64'({12'd2048, 12'd2048}));

    // Fixed waveform points with tuning word 0 and a cleared accumulator.
    for (int i = 0; i < 14; i++) begin
      cfgWrite(0, 1, vecs[i].offset, 1'b0);
      cfgWrite(0, 2, vecs[i].mode, 1'b0);
      cfgWrite(0, 3, 0, 1'b0);
      commitStep(1'b0);
      idle(2, 1'b0);
      check(vecs[i].name, 64'(chOut(0)), 64'(vecs[i].expected));
    end

    // Saw frequency: tuning 0x400 gives +64 per cycle and a wrap every 64 cycles.
    cfgWrite(0, 0, 'h400, 1'b0);
    cfgWrite(0, 1, 0, 1'b0);
    cfgWrite(0, 2, 2, 1'b0);
    cfgWrite(0, 3, 0, 1'b0);
    commitStep(1'b0);
    idle(2, 1'b1);
    check("saw_first", 64'(chOut(0)), 64'd0);
    sync_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      prev = chOut(0);
      idle(1, 1'b1);
      if (sync[0]) sync_cnt++;
      check("saw_step", 64'((chOut(0) - prev) & 12'hfff), 64'd64);
    end
    check("saw_sync_count", 64'(sync_cnt), 64'd2);

    // Atomic commit: a tuning write in the commit cycle only reaches the shadow.
    cfgWrite(0, 0, 'h100, 1'b0);
    cfgWrite(1, 0, 'h200, 1'b0);
    for (int c = 0; c < 2; c++) begin
      cfgWrite(c, 1, 0, 1'b0);
      cfgWrite(c, 2, 2, 1'b0);
      cfgWrite(c, 3, 0, 1'b0);
    end
    commitStep(1'b0);
    idle(4, 1'b1);
    applyStimulus(1'b0, 1'b1, 1, 0, 'h300, 1'b1, 1'b1);
    idle(3, 1'b1);
    prev  = chOut(0);
    prev1 = chOut(1);
    idle(1, 1'b1);
    check("atomic_ch0_step", 64'((chOut(0) - prev) & 12'hfff), 64'd16);
    check("atomic_old_tune", 64'((chOut(1) - prev1) & 12'hfff), 64'd32);
    commitStep(1'b1);
    idle(3, 1'b1);
    prev1 = chOut(1);
    idle(1, 1'b1);
    check("atomic_new_tune", 64'((chOut(1) - prev1) & 12'hfff), 64'd48);

    // Clear both free-running channels on one commit; outputs realign.
    cfgWrite(0, 0, 'h123, 1'b1);
    cfgWrite(1, 0, 'h456, 1'b1);
    commitStep(1'b1);
    idle(7, 1'b1);
    cfgWrite(0, 3, 0, 1'b1);
    cfgWrite(1, 3, 0, 1'b1);
    commitStep(1'b1);
    idle(2, 1'b1);
    check("clear_ch0", 64'(chOut(0)), 64'd0);
    check("clear_ch1", 64'(chOut(1)), 64'd0);

    // en gating with triangle on ch0 and square on ch1.
    cfgWrite(0, 0, 'h0800, 1'b0);
    cfgWrite(0, 2, 3, 1'b0);
    cfgWrite(1, 0, 'h1000, 1'b0);
    cfgWrite(1, 2, 1, 1'b0);
    cfgWrite(0, 3, 0, 1'b0);
    cfgWrite(1, 3, 0, 1'b0);
    commitStep(1'b0);
    for (int i = 0; i < 72; i++) idle(1, ((i / 3) % 2) == 0);

    // Randomized traffic, including writes to unused channels 2 and 3.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 1) == 1), $urandom_range(0, 3), $urandom_range(0, 3),
                    int'($urandom_range(0, AN - 1)), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-cycle clears outputs at once; a write during reset is lost.
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput();
    check("rst_out_data", 64'(out_data), 64'd0);
    applyStimulus(1'b1, 1'b1, 0, 1, 'h100, 1'b1, 1'b1);
    idle(3, 1'b0);
    commitStep(1'b0);
    idle(2, 1'b0);
    check("reset_discards_write", 64'(chOut(0)), 64'd2048);
    check("default_after_reset", 64'(out_data), 64'({12'd2048, 12'd2048}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
